soc_region_table: RTL

Runtime-programmable address-region table that replaces the fixed compile-time SoC address map with `NumRules` shadowed, committable rules. Each rule carries a base, a length and attributes (slave index, cached, executable). It sits between the boot/config master and the crossbar/cache front ends. A pipelined lookup port resolves an address to a slave index plus attributes, with one cycle of latency and valid/ready flow control.

---
 rtl/soc_region_table_if.sv | 41 ++++
 rtl/soc_region_table.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/soc_region_table_if.sv
// rtl/soc_region_table_if.sv - config and lookup bus bundle for soc_region_table
interface soc_region_table_if #(
   parameter int NumRules  = 16,
   parameter int AddrWidth = 64,
   parameter int SlvIdxW   = 4
);
   // config access port
   logic                           cfg_req_i;
   logic                           cfg_we_i;
   logic [$clog2(NumRules)+1:0]    cfg_addr_i;
   logic [AddrWidth-1:0]           cfg_wdata_i;
   logic                           cfg_gnt_o;
   logic                           cfg_rvalid_o;
   logic [AddrWidth-1:0]           cfg_rdata_o;
   logic                           cfg_err_o;

   // lookup request / result port
   logic                           lk_valid_i;
   logic                           lk_ready_o;
   logic [AddrWidth-1:0]           lk_addr_i;
   logic                           res_valid_o;
   logic                           res_ready_i;
   logic [SlvIdxW-1:0]             res_idx_o;
   logic                           res_hit_o;
   logic                           res_cached_o;
   logic                           res_exec_o;

   modport master (
      output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
      output lk_valid_i, lk_addr_i, res_ready_i,
      input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
      input  lk_ready_o, res_valid_o, res_idx_o, res_hit_o, res_cached_o, res_exec_o
   );

   modport slave (
      input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
      input  lk_valid_i, lk_addr_i, res_ready_i,
      output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
      output lk_ready_o, res_valid_o, res_idx_o, res_hit_o, res_cached_o, res_exec_o
   );
endinterface

// File: rtl/soc_region_table.sv
// rtl/soc_region_table.sv - runtime-programmable address-region table with shadow/active rules
module soc_region_table #(
   parameter int NumRules   = 16,
   parameter int NumSlaves  = 11,
   parameter int AddrWidth  = 64,
   parameter int DefaultIdx = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   soc_region_table_if.slave bus
);
   localparam int SlvIdxW = $clog2(NumSlaves);
   localparam int RuleW   = $clog2(NumRules);

   localparam logic [8:0]         NUM_SLV9 = 9'(NumSlaves);
   localparam logic [RuleW:0]     NUM_RULE = (RuleW+1)'(NumRules);
   localparam logic [SlvIdxW-1:0] DEF_IDX  = SlvIdxW'(DefaultIdx);

   localparam logic [1:0] FLD_BASE = 2'd0;
   localparam logic [1:0] FLD_LEN  = 2'd1;
   localparam logic [1:0] FLD_ATTR = 2'd2;
   localparam logic [1:0] FLD_CTRL = 2'd3;

   typedef struct packed {
      logic       exec;
      logic       cached;
      logic       valid;
      logic [7:0] idx;
   } attr_t;

   // shadow copy (config-visible) and active copy (lookup-visible)
   logic [AddrWidth-1:0] r_sh_base [NumRules];
   logic [AddrWidth-1:0] r_sh_len  [NumRules];
   attr_t                r_sh_attr [NumRules];
   logic [AddrWidth-1:0] r_ac_base [NumRules];
   logic [AddrWidth-1:0] r_ac_len  [NumRules];
   attr_t                r_ac_attr [NumRules];

   logic r_lock;
   logic r_dirty;

   logic                 r_cfg_rvalid;
   logic                 r_cfg_err;
   logic [AddrWidth-1:0] r_cfg_rdata;

   logic                 r_res_valid;
   logic                 r_res_hit;
   logic [SlvIdxW-1:0]   r_res_idx;
   logic                 r_res_cached;
   logic                 r_res_exec;

   logic [1:0]           w_fld;
   logic [RuleW-1:0]     w_rule;
   logic                 w_rule_ok;
   logic                 w_wr;
   logic                 w_is_ctrl;
   logic                 w_sh_wr;
   logic                 w_commit;
   logic                 w_set_lock;
   logic                 w_drop;
   logic [AddrWidth-1:0] w_rdata;
   logic                 w_lk_ready;
   logic                 w_lk_acc;
   logic                 w_hit;
   logic [SlvIdxW-1:0]   w_idx;
   logic                 w_cached;
   logic                 w_exec;

   // config decode: locked tables drop rule writes and commit, but still answer reads
   assign w_fld      = bus.cfg_addr_i[1:0];
   assign w_rule     = bus.cfg_addr_i[RuleW+1:2];
   assign w_rule_ok  = {1'b0, w_rule} < NUM_RULE;
   assign w_wr       = bus.cfg_req_i & bus.cfg_we_i;
   assign w_is_ctrl  = (w_fld == FLD_CTRL);
   assign w_sh_wr    = w_wr & ~w_is_ctrl & ~r_lock & w_rule_ok;
   assign w_commit   = w_wr & w_is_ctrl & ~r_lock & bus.cfg_wdata_i[0];
   assign w_set_lock = w_wr & w_is_ctrl & ~r_lock & bus.cfg_wdata_i[1];
   assign w_drop     = w_wr & r_lock & (~w_is_ctrl | bus.cfg_wdata_i[0]);

   assign bus.cfg_gnt_o    = bus.cfg_req_i;
   assign bus.cfg_rvalid_o = r_cfg_rvalid;
   assign bus.cfg_rdata_o  = r_cfg_rdata;
   assign bus.cfg_err_o    = r_cfg_err;

   // shadow writes, single-cycle commit into active, and sticky lock
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < NumRules; r++) begin
            r_sh_base[r] <= '0;
            r_sh_len[r]  <= '0;
            r_sh_attr[r] <= '0;
            r_ac_base[r] <= '0;
            r_ac_len[r]  <= '0;
            r_ac_attr[r] <= '0;
         end
         r_lock  <= 1'b0;
         r_dirty <= 1'b0;
      end else begin
         if (w_sh_wr) begin
            case (w_fld)
               FLD_BASE: r_sh_base[w_rule] <= bus.cfg_wdata_i;
               FLD_LEN:  r_sh_len[w_rule]  <= bus.cfg_wdata_i;
               default:  r_sh_attr[w_rule] <= attr_t'(bus.cfg_wdata_i[10:0]);
            endcase
            r_dirty <= 1'b1;
         end
         if (w_commit) begin
            for (int r = 0; r < NumRules; r++) begin
               r_ac_base[r] <= r_sh_base[r];
               r_ac_len[r]  <= r_sh_len[r];
               r_ac_attr[r] <= r_sh_attr[r];
            end
            r_dirty <= 1'b0;
         end
         if (w_set_lock) begin
            r_lock <= 1'b1;
         end
      end
   end

   // read mux over the shadow copy and CTRL
   always_comb begin
      w_rdata = '0;
      if (w_is_ctrl) begin
         w_rdata = {{(AddrWidth-3){1'b0}}, r_dirty, r_lock, 1'b0};
      end else if (w_rule_ok) begin
         case (w_fld)
            FLD_BASE: w_rdata = r_sh_base[w_rule];
            FLD_LEN:  w_rdata = r_sh_len[w_rule];
            FLD_ATTR: w_rdata = {{(AddrWidth-11){1'b0}}, r_sh_attr[w_rule]};
            default:  w_rdata = '0;
         endcase
      end
   end

   // config response one cycle after grant
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cfg_rvalid <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_cfg_rdata  <= '0;
      end else begin
         r_cfg_rvalid <= bus.cfg_req_i;
         r_cfg_err    <= w_drop;
         r_cfg_rdata  <= (bus.cfg_req_i & ~bus.cfg_we_i) ? w_rdata : '0;
      end
   end

   // priority match over the active table; scanning downward lets the lowest index win
   always_comb begin
      w_hit    = 1'b0;
      w_idx    = DEF_IDX;
      w_cached = 1'b0;
      w_exec   = 1'b0;
      for (int r = NumRules - 1; r >= 0; r--) begin
         if (r_ac_attr[r].valid && (r_ac_len[r] != '0) &&
             ({1'b0, r_ac_attr[r].idx} < NUM_SLV9) &&
             (bus.lk_addr_i >= r_ac_base[r]) &&
             ((bus.lk_addr_i - r_ac_base[r]) < r_ac_len[r])) begin
            w_hit    = 1'b1;
            w_idx    = r_ac_attr[r].idx[SlvIdxW-1:0];
            w_cached = r_ac_attr[r].cached;
            w_exec   = r_ac_attr[r].exec;
         end
      end
   end

   assign w_lk_ready      = ~r_res_valid | bus.res_ready_i;
   assign w_lk_acc        = bus.lk_valid_i & w_lk_ready;
   assign bus.lk_ready_o  = w_lk_ready;
   assign bus.res_valid_o = r_res_valid;
   assign bus.res_hit_o   = r_res_hit;
   assign bus.res_idx_o   = r_res_idx;
   assign bus.res_cached_o = r_res_cached;
   assign bus.res_exec_o  = r_res_exec;

   // single output stage: capture on accept, hold while stalled, drain on ready
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_res_valid  <= 1'b0;
         r_res_hit    <= 1'b0;
         r_res_idx    <= DEF_IDX;
         r_res_cached <= 1'b0;
         r_res_exec   <= 1'b0;
      end else if (w_lk_acc) begin
         r_res_valid  <= 1'b1;
         r_res_hit    <= w_hit;
         r_res_idx    <= w_idx;
         r_res_cached <= w_cached;
         r_res_exec   <= w_exec;
      end else if (bus.res_ready_i) begin
         r_res_valid  <= 1'b0;
      end
   end
endmodule
